// File: rtl/e203_ifu_pcgen.sv
// rtl/e203_ifu_pcgen.sv - IFU next-PC generator and single-outstanding fetch request sequencer
// Optional compressed-instruction support is enabled by defining E203_PCGEN_RVC_EN.
module e203_ifu_pcgen #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = 32'h0000_1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            prdt_taken,
  input  logic [PC_W-1:0] prdt_pc_add_op1,
  input  logic [PC_W-1:0] prdt_pc_add_op2,
  input  logic            bpu_wait,
  input  logic            cur_is_rv32,
  input  logic            ifu_rsp_valid,
  output logic            ifu_rsp_ready,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [PC_W-1:0] ifu_req_pc,
  output logic            rsp_drop,
  output logic [PC_W-1:0] pc,
  input  logic            pipe_flush_req,
  input  logic [PC_W-1:0] pipe_flush_pc,
  output logic            pipe_flush_ack,
  input  logic            halt_req,
  output logic            halt_ack
);

  typedef enum logic [1:0] {
    S_BOOT     = 2'd0,
    S_RUN      = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] flush_pc_r;
  logic            outstanding;
  logic            flush_pend;
  logic            drop_pend;

`ifdef E203_PCGEN_RVC_EN
  // Compressed instructions make every halfword a legal fetch address.
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(1));
  logic [PC_W-1:0] pc_inc;
  assign pc_inc = cur_is_rv32 ? PC_W'(4) : PC_W'(2);
`else
  // Without compressed support every instruction is a word; the size hint has no effect.
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(3));
  logic [PC_W-1:0] pc_inc;
  assign pc_inc = cur_is_rv32 ? PC_W'(4) : PC_W'(4);
`endif

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] prdt_pc;
  logic [PC_W-1:0] flush_tgt;
  logic            flush_active;
  logic            slot_free;
  logic            can_issue;
  logic            req_fire;

  // Candidate next-PC values; all adds wrap silently modulo 2^PC_W.
  assign seq_pc       = pc_r + pc_inc;
  assign prdt_pc      = (prdt_pc_add_op1 + prdt_pc_add_op2) & ALIGN_MASK;
  assign flush_active = pipe_flush_req | flush_pend;
  // A flush arriving this cycle wins over one already parked in the pending register.
  assign flush_tgt    = (pipe_flush_req ? pipe_flush_pc : flush_pc_r) & ALIGN_MASK;

  // A new request may go out once the bus slot frees up. A response that belongs to a
  // flushed request does not free the slot in its own cycle, so the redirect request
  // always follows one cycle behind the dropped response. Only a flush already parked in
  // the pending register lifts a BPU dependency stall.
  assign slot_free = ~outstanding | (ifu_rsp_valid & ~drop_pend);
  assign can_issue = ~halt_req & slot_free & (~bpu_wait | flush_pend);

  // Next-state and request outputs.
  always_comb begin
    state_nxt     = state;
    ifu_req_valid = 1'b0;
    ifu_req_pc    = flush_active ? flush_tgt : (prdt_taken ? prdt_pc : seq_pc);
    unique case (state)
      S_BOOT: begin
        ifu_req_valid = ~rst;
        ifu_req_pc    = flush_active ? flush_tgt : RESET_VEC;
        if (ifu_req_ready) begin
          state_nxt = S_WAIT_RSP;
        end
      end
      S_RUN: begin
        ifu_req_valid = can_issue & ~rst;
        if (can_issue & ifu_req_ready) begin
          state_nxt = S_WAIT_RSP;
        end else if (halt_req & ~outstanding) begin
          state_nxt = S_HALT;
        end
      end
      S_WAIT_RSP: begin
        ifu_req_valid = can_issue & ~rst;
        if (can_issue & ifu_req_ready) begin
          state_nxt = S_WAIT_RSP;
        end else if (ifu_rsp_valid) begin
          state_nxt = halt_req ? S_HALT : S_RUN;
        end
      end
      S_HALT: begin
        if (~halt_req) begin
          state_nxt = S_RUN;
        end
      end
      default: begin
        state_nxt = S_BOOT;
      end
    endcase
  end

  assign req_fire = ifu_req_valid & ifu_req_ready;

  // State register, architectural PC, outstanding tracking and flush bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_BOOT;
      pc_r        <= RESET_VEC;
      flush_pc_r  <= '0;
      outstanding <= 1'b0;
      flush_pend  <= 1'b0;
      drop_pend   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (req_fire) begin
        pc_r        <= ifu_req_pc;
        outstanding <= 1'b1;
        flush_pend  <= 1'b0;
      end else begin
        if (ifu_rsp_valid) begin
          outstanding <= 1'b0;
        end
        if (pipe_flush_req) begin
          flush_pend <= 1'b1;
          flush_pc_r <= pipe_flush_pc & ALIGN_MASK;
        end
      end
      // The in-flight response now fetches from the wrong path; mark it for discard.
      if (pipe_flush_req & outstanding & ~ifu_rsp_valid) begin
        drop_pend <= 1'b1;
      end else if (ifu_rsp_valid) begin
        drop_pend <= 1'b0;
      end
    end
  end

  assign pc             = pc_r;
  assign ifu_rsp_ready  = 1'b1;
  assign pipe_flush_ack = pipe_flush_req;
  // Responses with nothing outstanding (e.g. after a reset) are stale as well.
  assign rsp_drop       = ifu_rsp_valid & (drop_pend | ~outstanding) & ~rst;
  assign halt_ack       = (state == S_HALT) & ~rst;

endmodule

// File: tb/tb_e203_ifu_pcgen.sv
// tb/tb_e203_ifu_pcgen.sv - self-checking bench for e203_ifu_pcgen
module tb_e203_ifu_pcgen;

  localparam logic [31:0] RV = 32'h0000_1000;
`ifdef E203_PCGEN_RVC_EN
  localparam logic [31:0] AMASK = 32'hFFFF_FFFE;
  localparam bit          RVC   = 1'b1;
`else
  localparam logic [31:0] AMASK = 32'hFFFF_FFFC;
  localparam bit          RVC   = 1'b0;
`endif
  localparam logic [31:0] C4_PC = RVC ? 32'h0000_1006 : 32'h0000_1008;

  logic        clk = 1'b0;
  logic        rst;
  logic        prdt_taken;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        bpu_wait;
  logic        cur_is_rv32;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_pc;
  logic        rsp_drop;
  logic [31:0] pc;
  logic        pipe_flush_req;
  logic [31:0] pipe_flush_pc;
  logic        pipe_flush_ack;
  logic        halt_req;
  logic        halt_ack;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  e203_ifu_pcgen dut (
    .clk             (clk),
    .rst             (rst),
    .prdt_taken      (prdt_taken),
    .prdt_pc_add_op1 (op1),
    .prdt_pc_add_op2 (op2),
    .bpu_wait        (bpu_wait),
    .cur_is_rv32     (cur_is_rv32),
    .ifu_rsp_valid   (ifu_rsp_valid),
    .ifu_rsp_ready   (ifu_rsp_ready),
    .ifu_req_valid   (ifu_req_valid),
    .ifu_req_ready   (ifu_req_ready),
    .ifu_req_pc      (ifu_req_pc),
    .rsp_drop        (rsp_drop),
    .pc              (pc),
    .pipe_flush_req  (pipe_flush_req),
    .pipe_flush_pc   (pipe_flush_pc),
    .pipe_flush_ack  (pipe_flush_ack),
    .halt_req        (halt_req),
    .halt_ack        (halt_ack)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one fetch slot, an optional parked redirect, and a flag marking the
  // in-flight fetch as belonging to a squashed path.
  bit          m_started;
  bit          m_halted;
  bit          m_redir_v;
  bit          m_stale;
  int          m_inflight;
  logic [31:0] m_pc;
  logic [31:0] m_redir_pc;

  always @(negedge clk) begin : cmp
    bit          redir_now;
    bit          live_rsp;
    bit          e_valid;
    bit          e_drop;
    bit          hs;
    logic [31:0] redir_t;
    logic [31:0] e_pc;
    if (rst) begin
      chk("reset_req_valid", 32'(ifu_req_valid), 32'd0);
      m_started  = 1'b0;
      m_halted   = 1'b0;
      m_redir_v  = 1'b0;
      m_stale    = 1'b0;
      m_inflight = 0;
      m_pc       = RV;
      m_redir_pc = 32'd0;
    end else begin
      redir_now = pipe_flush_req || m_redir_v;
      redir_t   = (pipe_flush_req ? pipe_flush_pc : m_redir_pc) & AMASK;
      live_rsp  = ifu_rsp_valid && (m_inflight == 1) && !m_stale;
      if (!m_started) begin
        e_valid = 1'b1;
        e_pc    = redir_now ? redir_t : RV;
      end else begin
        e_valid = !m_halted && !halt_req && (m_inflight == 0 || live_rsp) && (!bpu_wait || m_redir_v);
        if (redir_now)       e_pc = redir_t;
        else if (prdt_taken) e_pc = (op1 + op2) & AMASK;
        else                 e_pc = m_pc + ((RVC && !cur_is_rv32) ? 32'd2 : 32'd4);
      end
      e_drop = ifu_rsp_valid && (m_inflight == 0 || m_stale);

      chk("req_valid", 32'(ifu_req_valid), 32'(e_valid));
      if (e_valid) chk("req_pc", ifu_req_pc, e_pc);
      chk("pc", pc, m_pc);
      chk("rsp_drop", 32'(rsp_drop), 32'(e_drop));
      chk("halt_ack", 32'(halt_ack), 32'(m_halted));
      chk("flush_ack", 32'(pipe_flush_ack), 32'(pipe_flush_req));
      chk("rsp_ready", 32'(ifu_rsp_ready), 32'd1);

      hs = e_valid && ifu_req_ready;
      if (hs) begin
        m_started  = 1'b1;
        m_pc       = e_pc;
        m_inflight = 1;
        m_stale    = 1'b0;
        m_redir_v  = 1'b0;
      end else begin
        if (pipe_flush_req) begin
          m_redir_v  = 1'b1;
          m_redir_pc = pipe_flush_pc;
          if (m_inflight == 1 && !ifu_rsp_valid) m_stale = 1'b1;
        end
        if (ifu_rsp_valid) begin
          m_inflight = 0;
          m_stale    = 1'b0;
        end
      end
      if (m_halted) begin
        if (!halt_req) m_halted = 1'b0;
      end else if (m_started && !hs && halt_req && m_inflight == 0) begin
        m_halted = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1; prdt_taken = 1'b0; op1 = '0; op2 = '0; bpu_wait = 1'b0; cur_is_rv32 = 1'b1;
    ifu_rsp_valid = 1'b0; ifu_req_ready = 1'b1; pipe_flush_req = 1'b0; pipe_flush_pc = '0; halt_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    // C1: boot request at the reset vector
    @(negedge clk);
    chk("lit_boot_valid", 32'(ifu_req_valid), 32'd1);
    chk("lit_boot_pc", ifu_req_pc, 32'h0000_1000);
    chk("lit_boot_halt_ack", 32'(halt_ack), 32'd0);
    tick();
    // C2: response, next request stalled by ready=0
    ifu_rsp_valid = 1'b1; ifu_req_ready = 1'b0;
    @(negedge clk);
    chk("lit_pc_after_boot", pc, 32'h0000_1000);
    chk("lit_seq32_pc", ifu_req_pc, 32'h0000_1004);
    tick();
    // C3: request held stable, accepted
    ifu_rsp_valid = 1'b0; ifu_req_ready = 1'b1;
    @(negedge clk);
    chk("lit_seq32_stable", ifu_req_pc, 32'h0000_1004);
    tick();
    // C4: 16-bit instruction in IR
    ifu_rsp_valid = 1'b1; cur_is_rv32 = 1'b0;
    @(negedge clk);
    chk("lit_seq16_pc", ifu_req_pc, C4_PC);
    tick();
    // C5, C6: taken predictions, second one wraps
    cur_is_rv32 = 1'b1; prdt_taken = 1'b1; op1 = 32'h0000_2000; op2 = 32'hFFFF_FFF0;
    @(negedge clk);
    chk("lit_taken_pc", ifu_req_pc, 32'h0000_1FF0);
    tick();
    op1 = 32'hFFFF_FFFC; op2 = 32'h0000_0008;
    @(negedge clk);
    chk("lit_taken_wrap", ifu_req_pc, 32'h0000_0004);
    tick();
    // C7: flush while the request is outstanding
    prdt_taken = 1'b0; op1 = '0; op2 = '0; ifu_rsp_valid = 1'b0; ifu_req_ready = 1'b0;
    pipe_flush_req = 1'b1; pipe_flush_pc = 32'h0000_8000;
    @(negedge clk);
    chk("lit_flush_ack", 32'(pipe_flush_ack), 32'd1);
    tick();
    // C8: stale response is dropped and releases nothing
    pipe_flush_req = 1'b0; ifu_rsp_valid = 1'b1;
    @(negedge clk);
    chk("lit_stale_drop", 32'(rsp_drop), 32'd1);
    chk("lit_stale_no_req", 32'(ifu_req_valid), 32'd0);
    tick();
    // C9, C10: redirect request
    ifu_rsp_valid = 1'b0;
    @(negedge clk);
    chk("lit_flush_req_pc", ifu_req_pc, 32'h0000_8000);
    tick();
    ifu_req_ready = 1'b1;
    @(negedge clk);
    tick();
    // C11..C13: bpu_wait, flush arrives in its second cycle
    ifu_rsp_valid = 1'b1; bpu_wait = 1'b1;
    @(negedge clk);
    chk("lit_bpu_wait_valid", 32'(ifu_req_valid), 32'd0);
    tick();
    ifu_rsp_valid = 1'b0; pipe_flush_req = 1'b1; pipe_flush_pc = 32'h0000_9000;
    @(negedge clk);
    tick();
    pipe_flush_req = 1'b0;
    @(negedge clk);
    chk("lit_bpu_flush_valid", 32'(ifu_req_valid), 32'd1);
    chk("lit_bpu_flush_pc", ifu_req_pc, 32'h0000_9000);
    chk("lit_bpu_pc_held", pc, 32'h0000_8000);
    tick();
    // C14..C19: halt with a request outstanding, then release
    bpu_wait = 1'b0; halt_req = 1'b1;
    @(negedge clk);
    tick();
    ifu_rsp_valid = 1'b1;
    @(negedge clk);
    chk("lit_halt_ack_early", 32'(halt_ack), 32'd0);
    tick();
    ifu_rsp_valid = 1'b0;
    @(negedge clk);
    chk("lit_halt_ack", 32'(halt_ack), 32'd1);
    tick();
    @(negedge clk);
    tick();
    halt_req = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("lit_resume_ack", 32'(halt_ack), 32'd0);
    chk("lit_resume_pc", ifu_req_pc, 32'h0000_9004);
    tick();
    // C20..C22: reset mid-request, late response afterwards
    @(negedge clk);
    tick();
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0; ifu_rsp_valid = 1'b1;
    @(negedge clk);
    chk("lit_late_rsp_drop", 32'(rsp_drop), 32'd1);
    chk("lit_reboot_pc", ifu_req_pc, 32'h0000_1000);
    tick();
    @(negedge clk);
    tick();
    ifu_rsp_valid = 1'b0;
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
